// File: rtl/alu_pkg.sv
// Shared constants, FSM encoding and decoded-instruction payload for the ALU decode/issue stage.
package alu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 3;

  // ALU opcodes
  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SLL = 3'b001;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b010;
  localparam logic [OP_W-1:0] ALU_XOR = 3'b100;
  localparam logic [OP_W-1:0] ALU_SHR = 3'b101;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b110;
  localparam logic [OP_W-1:0] ALU_AND = 3'b111;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Branch funct3
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  typedef enum logic {
    ST_IDLE       = 1'b0,
    ST_WAIT_FLAGS = 1'b1
  } state_t;

  typedef struct packed {
    logic             legal;
    logic [OP_W-1:0]  op;
    logic             use_imm;
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             is_branch;
    logic [2:0]       funct3;
  } dec_t;

  // funct3 to ALU op for OP/OP-IMM; funct3 000 selects SUB only when requested
  function automatic logic [OP_W-1:0] alu_op_of_f3(input logic [2:0] f3, input logic sub);
    logic [OP_W-1:0] op;
    case (f3)
      3'b000:  op = sub ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SHR;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// Pure combinational RV32I instruction-to-ALU-controls decoder.
module alu_decode_comb
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output dec_t            dec
);

  logic [6:0] opc;
  logic [2:0] f3;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];

  // Field extraction; unused fields pass raw instruction bits through
  always_comb begin
    dec           = '0;
    dec.op        = ALU_ADD;
    dec.imm       = instr;
    dec.rd        = instr[11:7];
    dec.rs1       = instr[19:15];
    dec.rs2       = instr[24:20];
    dec.funct3    = f3;
    case (opc)
      OPC_OP: begin
        dec.legal = (f3 != 3'b010) && (f3 != 3'b011);
        dec.op    = alu_op_of_f3(f3, instr[30]);
      end
      OPC_OP_IMM: begin
        dec.legal   = (f3 != 3'b010) && (f3 != 3'b011);
        dec.op      = alu_op_of_f3(f3, 1'b0);
        dec.use_imm = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.imm = XLEN'(instr[24:20]);
        end else begin
          dec.imm = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_LOAD: begin
        dec.legal   = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        dec.legal   = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        dec.rd      = '0;
      end
      OPC_BRANCH: begin
        dec.legal     = (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) || (f3 == F3_BGE);
        dec.op        = ALU_SUB;
        dec.is_branch = 1'b1;
      end
      default: dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_decode_issue.sv
// Decode/issue stage: one-entry output register, branch-wait FSM, illegal-instruction counter.
module alu_decode_issue
  import alu_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [XLEN-1:0]   instr,
  output logic              instr_ready,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [OP_W-1:0]   alu_op,
  output logic              use_imm,
  output logic [XLEN-1:0]   imm,
  output logic [REG_W-1:0]  rd,
  output logic [REG_W-1:0]  rs1,
  output logic [REG_W-1:0]  rs2,
  output logic              is_branch,
  input  logic              flags_valid,
  input  logic              status_ZF,
  input  logic              status_SF,
  output logic              br_valid,
  output logic              br_taken,
  output logic              illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  dec_t       dec;
  state_t     state_q, state_d;
  logic       br_valid_d, br_taken_d;
  logic [2:0] funct3_q;
  logic       xfer, br_xfer, accept;

  alu_decode_comb u_dec (
    .instr (instr),
    .dec   (dec)
  );

  assign xfer        = alu_valid & alu_ready;
  assign br_xfer     = xfer & is_branch;
  assign instr_ready = (state_q == ST_IDLE) & (~alu_valid | alu_ready) & ~br_xfer;
  assign accept      = instr_valid & instr_ready;

  // Branch-wait next state and branch resolution
  always_comb begin
    state_d    = state_q;
    br_valid_d = 1'b0;
    br_taken_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (br_xfer) state_d = ST_WAIT_FLAGS;
      end
      ST_WAIT_FLAGS: begin
        if (flags_valid) begin
          state_d    = ST_IDLE;
          br_valid_d = 1'b1;
          case (funct3_q)
            F3_BEQ:  br_taken_d = status_ZF;
            F3_BNE:  br_taken_d = ~status_ZF;
            F3_BLT:  br_taken_d = status_SF;
            F3_BGE:  br_taken_d = ~status_SF;
            default: br_taken_d = 1'b0;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered branch-resolution pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      br_valid <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      state_q  <= state_d;
      br_valid <= br_valid_d;
      br_taken <= br_taken_d;
    end
  end

  // One-entry output register; reloads on the same edge it drains
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_valid <= 1'b0;
      alu_op    <= '0;
      use_imm   <= 1'b0;
      imm       <= '0;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      is_branch <= 1'b0;
      funct3_q  <= '0;
    end else if (accept && dec.legal) begin
      alu_valid <= 1'b1;
      alu_op    <= dec.op;
      use_imm   <= dec.use_imm;
      imm       <= dec.imm;
      rd        <= dec.rd;
      rs1       <= dec.rs1;
      rs2       <= dec.rs2;
      is_branch <= dec.is_branch;
      funct3_q  <= dec.funct3;
    end else if (xfer) begin
      alu_valid <= 1'b0;
    end
  end

  // Illegal-instruction pulse and saturating counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      illegal <= accept & ~dec.legal;
      if (accept && !dec.legal && (illegal_cnt != {CNT_W{1'b1}})) begin
        illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_decode_issue.sv
// Self-checking bench for alu_decode_issue: decode table, handshake/branch sequences, random stream.
module tb_alu_decode_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  alu_op;
  logic        use_imm;
  logic [31:0] imm;
  logic [4:0]  rd, rs1, rs2;
  logic        is_branch;
  logic        flags_valid;
  logic        status_ZF, status_SF;
  logic        br_valid, br_taken;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [31:0] w;
    logic        legal;
    logic [2:0]  op;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic        chk_rs2;
  } exp_t;

  alu_decode_issue #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_op(alu_op), .use_imm(use_imm), .imm(imm), .rd(rd), .rs1(rs1), .rs2(rs2),
    .is_branch(is_branch), .flags_valid(flags_valid), .status_ZF(status_ZF),
    .status_SF(status_SF), .br_valid(br_valid), .br_taken(br_taken),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [31:0] w, input logic legal, input logic [2:0] op,
                              input logic ui, input logic [31:0] im, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2, input logic c2);
    exp_t e;
    e.w = w; e.legal = legal; e.op = op; e.use_imm = ui; e.imm = im;
    e.rd = d; e.rs1 = s1; e.rs2 = s2; e.chk_rs2 = c2;
    return e;
  endfunction

  // Reference decode from the ISA rules (branches not used in the random stream)
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    int f3 = int'(w[14:12]);
    e = mk(w, 1'b0, 3'd0, 1'b0, 32'd0, w[11:7], w[19:15], w[24:20], 1'b0);
    case (w[6:0])
      7'h33: begin
        e.legal = !(f3 == 2 || f3 == 3);
        e.op = (f3 == 0) ? (w[30] ? 3'd2 : 3'd0) : 3'(f3);
        e.chk_rs2 = 1'b1;
      end
      7'h13: begin
        e.legal = !(f3 == 2 || f3 == 3);
        e.op = 3'(f3);
        e.use_imm = 1'b1;
        if (f3 == 1 || f3 == 5) e.imm = 32'(w[24:20]);
        else e.imm = 32'($signed(w[31:20]));
      end
      7'h03: begin
        e.legal = 1'b1; e.use_imm = 1'b1; e.imm = 32'($signed(w[31:20]));
      end
      7'h23: begin
        e.legal = 1'b1; e.use_imm = 1'b1; e.rd = 5'd0; e.chk_rs2 = 1'b1;
        e.imm = 32'($signed({w[31:25], w[11:7]}));
      end
      default: e.legal = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w = $urandom();
    case ($urandom_range(0, 5))
      0, 1: begin
        w[6:0] = 7'h33;
        w[31:25] = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0;
      end
      2: begin
        w[6:0] = 7'h13;
        if (w[14:12] == 3'd1) w[31:25] = 7'b0;
        if (w[14:12] == 3'd5) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0;
      end
      3: w[6:0] = 7'h03;
      4: w[6:0] = 7'h23;
      default: if (w[6:0] == 7'h63) w[6:0] = 7'h7f;
    endcase
    return w;
  endfunction

  task automatic cmp_fields(input string tag, input exp_t e);
    chk({tag, "_op"}, 32'(alu_op), 32'(e.op));
    chk({tag, "_uimm"}, 32'(use_imm), 32'(e.use_imm));
    chk({tag, "_rd"}, 32'(rd), 32'(e.rd));
    chk({tag, "_rs1"}, 32'(rs1), 32'(e.rs1));
    chk({tag, "_isbr"}, 32'(is_branch), 32'd0);
    if (e.use_imm) chk({tag, "_imm"}, imm, e.imm);
    if (e.chk_rs2) chk({tag, "_rs2"}, 32'(rs2), 32'(e.rs2));
  endtask

  task automatic note_illegal();
    if (exp_cnt < 255) exp_cnt++;
  endtask

  // Issue a branch, hold flags off for a while, then resolve with given flags
  task automatic do_branch(input logic [31:0] w, input logic zf, input logic sf,
                           input logic taken, input int waits);
    cyc(); instr_valid = 1'b1; instr = w; alu_ready = 1'b0; #1;
    chk("br_acc_rdy", 32'(instr_ready), 32'd1);
    cyc(); instr_valid = 1'b1; instr = 32'h002081B3; #1;
    chk("br_valid_op", 32'(alu_valid), 32'd1);
    chk("br_op", 32'(alu_op), 32'd2);
    chk("br_isbr", 32'(is_branch), 32'd1);
    chk("br_uimm", 32'(use_imm), 32'd0);
    alu_ready = 1'b1; #1;
    chk("br_xfer_rdy", 32'(instr_ready), 32'd0);
    cyc(); alu_ready = 1'b0; #1;
    chk("br_drained", 32'(alu_valid), 32'd0);
    for (int k = 0; k < waits; k++) begin
      chk("br_wait_rdy", 32'(instr_ready), 32'd0);
      chk("br_wait_bv", 32'(br_valid), 32'd0);
      cyc();
    end
    flags_valid = 1'b1; status_ZF = zf; status_SF = sf; #1;
    chk("br_flag_bv", 32'(br_valid), 32'd0);
    cyc(); flags_valid = 1'b0; instr_valid = 1'b0; #1;
    chk("br_bv", 32'(br_valid), 32'd1);
    chk("br_taken", 32'(br_taken), 32'(taken));
    chk("br_done_rdy", 32'(instr_ready), 32'd1);
    chk("br_no_issue", 32'(alu_valid), 32'd0);
    cyc(); #1;
    chk("br_bv_pulse", 32'(br_valid), 32'd0);
  endtask

  exp_t vt[19];
  exp_t q[$];

  initial begin
    logic exp_ill;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; alu_ready = 1'b0;
    flags_valid = 1'b0; status_ZF = 1'b0; status_SF = 1'b0;

    repeat (3) cyc();
    chk("rst_valid", 32'(alu_valid), 32'd0);
    chk("rst_op", 32'(alu_op), 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_regs", 32'({rd, rs1, rs2, use_imm, is_branch}), 32'd0);
    chk("rst_br", 32'({br_valid, br_taken}), 32'd0);
    chk("rst_ill", 32'(illegal), 32'd0);
    chk("rst_cnt", 32'(illegal_cnt), 32'd0);
    rst_n = 1'b1; #1;
    chk("rst_rdy", 32'(instr_ready), 32'd1);

    vt[0]  = mk(32'h002081B3, 1, 3'd0, 0, 32'h0,        3, 1, 2, 1);
    vt[1]  = mk(32'h402081B3, 1, 3'd2, 0, 32'h0,        3, 1, 2, 1);
    vt[2]  = mk(32'hFFF00093, 1, 3'd0, 1, 32'hFFFFFFFF, 1, 0, 0, 0);
    vt[3]  = mk(32'h4040D093, 1, 3'd5, 1, 32'h4,        1, 1, 0, 0);
    vt[4]  = mk(32'h002091B3, 1, 3'd1, 0, 32'h0,        3, 1, 2, 1);
    vt[5]  = mk(32'h0020C1B3, 1, 3'd4, 0, 32'h0,        3, 1, 2, 1);
    vt[6]  = mk(32'h0020D1B3, 1, 3'd5, 0, 32'h0,        3, 1, 2, 1);
    vt[7]  = mk(32'h4020D1B3, 1, 3'd5, 0, 32'h0,        3, 1, 2, 1);
    vt[8]  = mk(32'h0020E1B3, 1, 3'd6, 0, 32'h0,        3, 1, 2, 1);
    vt[9]  = mk(32'h0020F1B3, 1, 3'd7, 0, 32'h0,        3, 1, 2, 1);
    vt[10] = mk(32'hFFC12283, 1, 3'd0, 1, 32'hFFFFFFFC, 5, 2, 0, 0);
    vt[11] = mk(32'h00612423, 1, 3'd0, 1, 32'h8,        0, 2, 6, 1);
    vt[12] = mk(32'hFE612823, 1, 3'd0, 1, 32'hFFFFFFF0, 0, 2, 6, 1);
    vt[13] = mk(32'h7FF14093, 1, 3'd4, 1, 32'h7FF,      1, 2, 0, 0);
    vt[14] = mk(32'h01F09093, 1, 3'd1, 1, 32'd31,       1, 1, 0, 0);
    vt[15] = mk(32'h40000093, 1, 3'd0, 1, 32'h400,      1, 0, 0, 0);
    vt[16] = mk(32'h0020A1B3, 0, 3'd0, 0, 32'h0,        0, 0, 0, 0);
    vt[17] = mk(32'h00513093, 0, 3'd0, 0, 32'h0,        0, 0, 0, 0);
    vt[18] = mk(32'h0020A463, 0, 3'd0, 0, 32'h0,        0, 0, 0, 0);

    foreach (vt[i]) begin
      cyc(); instr_valid = 1'b1; instr = vt[i].w; alu_ready = 1'b0; #1;
      chk("tbl_rdy", 32'(instr_ready), 32'd1);
      cyc(); instr_valid = 1'b0; #1;
      chk($sformatf("tbl%0d_valid", i), 32'(alu_valid), 32'(vt[i].legal));
      chk($sformatf("tbl%0d_ill", i), 32'(illegal), 32'(!vt[i].legal));
      if (!vt[i].legal) note_illegal();
      chk($sformatf("tbl%0d_cnt", i), 32'(illegal_cnt), 32'(exp_cnt));
      if (vt[i].legal) cmp_fields($sformatf("tbl%0d", i), vt[i]);
      alu_ready = 1'b1;
      cyc(); alu_ready = 1'b0; #1;
      chk("tbl_drain", 32'(alu_valid), 32'd0);
      chk("tbl_ill_pulse", 32'(illegal), 32'd0);
    end

    // Back-pressure hold, then consume and accept on the same edge
    cyc(); instr_valid = 1'b1; instr = 32'h402081B3; alu_ready = 1'b0;
    cyc(); instr = 32'h002081B3; #1;
    for (int k = 0; k < 3; k++) begin
      chk("hold_op", 32'(alu_op), 32'd2);
      chk("hold_valid", 32'(alu_valid), 32'd1);
      chk("hold_rdy", 32'(instr_ready), 32'd0);
      cyc();
    end
    alu_ready = 1'b1; #1;
    chk("rel_rdy", 32'(instr_ready), 32'd1);
    cyc(); instr_valid = 1'b0; alu_ready = 1'b0; #1;
    chk("reload_valid", 32'(alu_valid), 32'd1);
    chk("reload_op", 32'(alu_op), 32'd0);
    alu_ready = 1'b1;
    cyc(); alu_ready = 1'b0; #1;
    chk("reload_drain", 32'(alu_valid), 32'd0);

    do_branch(32'h00208463, 1'b1, 1'b0, 1'b1, 3);
    do_branch(32'h0020C463, 1'b1, 1'b0, 1'b0, 1);
    do_branch(32'h00209463, 1'b0, 1'b1, 1'b1, 0);
    do_branch(32'h0020D463, 1'b0, 1'b1, 1'b0, 2);
    do_branch(32'h00208463, 1'b0, 1'b1, 1'b0, 0);

    // Flags while idle are ignored
    flags_valid = 1'b1; status_ZF = 1'b1;
    cyc(); cyc(); flags_valid = 1'b0; #1;
    chk("idle_flags_bv", 32'(br_valid), 32'd0);

    // Counter saturates
    instr_valid = 1'b1; instr = 32'h0020A1B3; alu_ready = 1'b0;
    for (int k = 0; k < 300; k++) begin
      cyc();
      note_illegal();
    end
    instr_valid = 1'b0;
    cyc();
    chk("sat_cnt", 32'(illegal_cnt), 32'd255);
    chk("sat_model", 32'(illegal_cnt), 32'(exp_cnt));
    chk("sat_valid", 32'(alu_valid), 32'd0);

    // Reset while waiting for flags abandons the branch
    cyc(); instr_valid = 1'b1; instr = 32'h00208463;
    cyc(); instr_valid = 1'b0; alu_ready = 1'b1;
    cyc(); alu_ready = 1'b0;
    cyc(); #1;
    chk("rw_waiting", 32'(instr_ready), 32'd0);
    rst_n = 1'b0; flags_valid = 1'b1; status_ZF = 1'b1;
    cyc(); rst_n = 1'b1; flags_valid = 1'b0; #1;
    chk("rw_bv", 32'(br_valid), 32'd0);
    chk("rw_valid", 32'(alu_valid), 32'd0);
    chk("rw_cnt", 32'(illegal_cnt), 32'd0);
    chk("rw_regs", 32'({alu_op, rd, rs1, rs2, use_imm, is_branch, br_taken, illegal}), 32'd0);
    chk("rw_rdy", 32'(instr_ready), 32'd1);
    cyc();
    chk("rw_bv_after", 32'(br_valid), 32'd0);
    exp_cnt = 0;

    // Random stream against the reference model
    q.delete();
    exp_ill = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic exp_rdy;
      exp_t d;
      cyc();
      chk("rnd_valid", 32'(alu_valid), 32'(q.size() != 0));
      if (q.size() != 0 && alu_valid) cmp_fields("rnd", q[0]);
      chk("rnd_ill", 32'(illegal), 32'(exp_ill));
      chk("rnd_cnt", 32'(illegal_cnt), 32'(exp_cnt));
      chk("rnd_bv", 32'(br_valid), 32'd0);
      instr_valid = ($urandom_range(0, 3) != 0);
      instr = gen_instr();
      alu_ready = ($urandom_range(0, 1) != 0);
      flags_valid = ($urandom_range(0, 7) == 0);
      #1;
      exp_rdy = (q.size() == 0) || alu_ready;
      chk("rnd_rdy", 32'(instr_ready), 32'(exp_rdy));
      if (q.size() != 0 && alu_ready) void'(q.pop_front());
      exp_ill = 1'b0;
      if (instr_valid && exp_rdy) begin
        d = ref_decode(instr);
        if (d.legal) q.push_back(d);
        else begin
          exp_ill = 1'b1;
          note_illegal();
        end
      end
    end
    instr_valid = 1'b0; alu_ready = 1'b1; flags_valid = 1'b0;
    cyc(); cyc();
    chk("end_drain", 32'(alu_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
